// File: rtl/move_controller_pkg.sv
// Shared types and constants for the 4x4 board move controller and its cursor.
package move_controller_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWrite,
        StDone
    } state_e;

    localparam logic [1:0]  CELL_EMPTY      = 2'b00;
    localparam logic [1:0]  P1_CODE_DEFAULT = 2'b01;
    localparam logic [1:0]  P2_CODE_DEFAULT = 2'b10;
    localparam int unsigned BOARD_CELLS     = 16;

    // Extracts the 2-bit code of cell idx from the packed board.
    function automatic logic [1:0] cell_at(input logic [31:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/cursor_wrap.sv
// Registered 2-bit row/column cursor with wrap-around moves and a hold enable.
module cursor_wrap (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en_i,
    input  logic       row_dec_i,
    input  logic       row_inc_i,
    input  logic       col_dec_i,
    input  logic       col_inc_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic [1:0] row_next_o,
    output logic [1:0] col_next_o
);

    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;

    // Two-bit arithmetic gives the mod-4 wrap for free.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (en_i) begin
            if (row_dec_i) begin
                row_d = row_q - 2'd1;
            end else if (row_inc_i) begin
                row_d = row_q + 2'd1;
            end else if (col_dec_i) begin
                col_d = col_q - 2'd1;
            end else if (col_inc_i) begin
                col_d = col_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign row_next_o = row_d;
    assign col_next_o = col_d;

endmodule

// File: rtl/move_controller.sv
// Cursor/placement controller for a 4x4 two-player board; drives a downstream
// 1-to-16 demux (select/piece) and a board register write strobe.
module move_controller
    import move_controller_pkg::*;
#(
    parameter logic [1:0] P1_CODE = P1_CODE_DEFAULT,
    parameter logic [1:0] P2_CODE = P2_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    input  logic [31:0] board,
    output logic [3:0]  select,
    output logic [1:0]  piece,
    output logic        write_en,
    output logic        turn,
    output logic [4:0]  move_count,
    output logic        rejected,
    output logic        game_over
);

    state_e     state_q, state_d;
    logic       turn_q, turn_d;
    logic [4:0] count_q, count_d;
    logic       write_en_q, write_en_d;
    logic       rejected_q, rejected_d;
    logic       game_over_q, game_over_d;
    logic [1:0] piece_q, piece_d;

    logic [1:0] row, col, row_next, col_next;
    logic       cursor_en;

    // The cursor only moves in IDLE and a placement request masks any move.
    assign cursor_en = (state_q == StIdle) && !btn_place;

    cursor_wrap u_cursor_wrap (
        .clk        (clk),
        .resetn     (resetn),
        .en_i       (cursor_en),
        .row_dec_i  (btn_up),
        .row_inc_i  (btn_down),
        .col_dec_i  (btn_left),
        .col_inc_i  (btn_right),
        .row_o      (row),
        .col_o      (col),
        .row_next_o (row_next),
        .col_next_o (col_next)
    );

    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        count_d    = count_q;
        write_en_d = 1'b0;
        rejected_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_place) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cell_at(board, {row, col}) != CELL_EMPTY) begin
                    rejected_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                write_en_d = 1'b1;
                turn_d     = ~turn_q;
                count_d    = count_q + 5'd1;
                state_d    = (count_d == 5'(BOARD_CELLS)) ? StDone : StIdle;
            end
            StDone: begin
            end
        endcase
        game_over_d = (state_d == StDone);
        // Outside the strobe, echo the addressed cell so the demux rewrites it unchanged.
        piece_d = write_en_d ? (turn_q ? P2_CODE : P1_CODE)
                             : cell_at(board, {row_next, col_next});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            turn_q      <= 1'b0;
            count_q     <= 5'd0;
            write_en_q  <= 1'b0;
            rejected_q  <= 1'b0;
            game_over_q <= 1'b0;
            piece_q     <= CELL_EMPTY;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            count_q     <= count_d;
            write_en_q  <= write_en_d;
            rejected_q  <= rejected_d;
            game_over_q <= game_over_d;
            piece_q     <= piece_d;
        end
    end

    assign select     = {row, col};
    assign piece      = piece_q;
    assign write_en   = write_en_q;
    assign turn       = turn_q;
    assign move_count = count_q;
    assign rejected   = rejected_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed vector tables plus random play against a
// cell-array reference model with a modelled downstream board register.
module tb_move_controller;

    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;

    // Button encoding {place, up, down, left, right}.
    localparam logic [4:0] B0 = 5'b00000;
    localparam logic [4:0] BP = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    typedef struct {
        logic [4:0] btn;
        logic [3:0] sel;
        logic       we;
        logic       rj;
        logic       turn;
        logic [4:0] cnt;
        logic       go;
        logic [1:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_place = 1'b0;
    logic [31:0] board = 32'd0;
    logic [3:0]  select;
    logic [1:0]  piece;
    logic        write_en, turn, rejected, game_over;
    logic [4:0]  move_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [1:0] cells [16];
    logic       cap_pending = 1'b0;
    int         cap_idx = 0;
    logic [1:0] cap_val = 2'b00;

    int         m_row, m_col, m_age, m_cnt;
    logic       m_turn, m_we, m_rj;
    logic [1:0] m_pc;

    vec_t tbl [18];
    vec_t hand [16];

    move_controller dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_place  (btn_place),
        .board      (board),
        .select     (select),
        .piece      (piece),
        .write_en   (write_en),
        .turn       (turn),
        .move_count (move_count),
        .rejected   (rejected),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack_board();
        logic [31:0] b;
        for (int i = 0; i < 16; i++) b[2*i +: 2] = cells[i];
        return b;
    endfunction

    task automatic drive_btn(input logic [4:0] b);
        {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // Advance one clock; the downstream register captures the strobe seen in the last cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cap_pending) cells[cap_idx] = cap_val;
        cap_pending = 1'b0;
        board = pack_board();
    endtask

    task automatic check(input string name, input logic [3:0] e_sel, input logic e_we,
                         input logic e_rj, input logic e_turn, input logic [4:0] e_cnt,
                         input logic e_go, input logic [1:0] e_pc);
        n_vec++;
        if ({select, write_en, rejected, turn, move_count, game_over, piece} !==
            {e_sel, e_we, e_rj, e_turn, e_cnt, e_go, e_pc}) begin
            n_bad++;
            $display("FAIL %s: got sel=%h we=%b rj=%b turn=%b cnt=%0d go=%b piece=%b; want sel=%h we=%b rj=%b turn=%b cnt=%0d go=%b piece=%b",
                     name, select, write_en, rejected, turn, move_count, game_over, piece,
                     e_sel, e_we, e_rj, e_turn, e_cnt, e_go, e_pc);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_age = -1; m_cnt = 0;
        m_turn = 1'b0; m_we = 1'b0; m_rj = 1'b0; m_pc = 2'b00;
    endtask

    task automatic do_reset();
        drive_btn(B0);
        resetn = 1'b0;
        #2;
        cap_pending = 1'b0;
        model_reset();
        check("reset", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // m_age: -1 waiting for input, 0 placement just requested, 1 cell found empty.
    task automatic model_step(input logic [4:0] b);
        int idx;
        m_we = 1'b0;
        m_rj = 1'b0;
        idx  = m_row * 4 + m_col;
        if (m_cnt == 16) begin
        end else if (m_age < 0) begin
            if (b[4])      m_age = 0;
            else if (b[3]) m_row = (m_row + 3) % 4;
            else if (b[2]) m_row = (m_row + 1) % 4;
            else if (b[1]) m_col = (m_col + 3) % 4;
            else if (b[0]) m_col = (m_col + 1) % 4;
        end else if (m_age == 0) begin
            if (cells[idx] != 2'b00) begin
                m_rj  = 1'b1;
                m_age = -1;
            end else begin
                m_age = 1;
            end
        end else begin
            m_we  = 1'b1;
            m_age = -1;
        end
        idx  = m_row * 4 + m_col;
        m_pc = m_we ? (m_turn ? P2 : P1) : cells[idx];
        if (m_we) begin
            m_turn = ~m_turn;
            m_cnt  = m_cnt + 1;
        end
    endtask

    task automatic cycle_model(input logic [4:0] b, input string name);
        model_step(b);
        drive_btn(b);
        tick();
        drive_btn(B0);
        check(name, 4'(m_row * 4 + m_col), m_we, m_rj, m_turn, 5'(m_cnt), m_cnt == 16, m_pc);
        if (m_we) begin
            cap_pending = 1'b1;
            cap_idx     = m_row * 4 + m_col;
            cap_val     = m_pc;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        drive_btn(v.btn);
        tick();
        drive_btn(B0);
        check(name, v.sel, v.we, v.rj, v.turn, v.cnt, v.go, v.pc);
        if (v.we) begin
            cap_pending = 1'b1;
            cap_idx     = int'(v.sel);
            cap_val     = v.pc;
        end
    endtask

    function automatic logic [4:0] rand_btn();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: return BP;
            3:       return BU;
            4:       return BD;
            5:       return BL;
            6:       return BR;
            7:       return 5'($urandom);
            default: return B0;
        endcase
    endfunction

    task automatic clear_cells();
        for (int i = 0; i < 16; i++) cells[i] = 2'b00;
        board = pack_board();
    endtask

    initial begin
        // Cursor walk, first placement, rejection on the same cell, second placement.
        tbl[0]  = '{BR,      4'd1,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[1]  = '{BR,      4'd2,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[2]  = '{BR,      4'd3,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[3]  = '{BR,      4'd0,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[4]  = '{BR,      4'd1,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[5]  = '{BU,      4'd13, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[6]  = '{BP,      4'd13, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[7]  = '{B0,      4'd13, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        tbl[8]  = '{B0,      4'd13, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, P1};
        tbl[9]  = '{B0,      4'd13, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 2'b00};
        tbl[10] = '{BP | BL, 4'd13, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, P1};
        tbl[11] = '{BD,      4'd13, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, P1};
        tbl[12] = '{B0,      4'd13, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, P1};
        tbl[13] = '{BD,      4'd1,  1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 2'b00};
        tbl[14] = '{BP,      4'd1,  1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 2'b00};
        tbl[15] = '{B0,      4'd1,  1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 2'b00};
        tbl[16] = '{B0,      4'd1,  1'b1, 1'b0, 1'b0, 5'd2, 1'b0, P2};
        tbl[17] = '{B0,      4'd1,  1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 2'b00};

        // Occupied cell 0 is refused, then the same cell placed once emptied.
        hand[0] = '{BP, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, P2};
        hand[1] = '{B0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, P2};
        hand[2] = '{B0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, P2};
        hand[3] = '{BP, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        hand[4] = '{B0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00};
        hand[5] = '{B0, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, P1};
        hand[6] = '{B0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 2'b00};
        hand[7] = '{B0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, P1};

        clear_cells();
        do_reset();
        for (int i = 0; i < 18; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        clear_cells();
        cells[0] = P2;
        board = pack_board();
        do_reset();
        for (int i = 0; i < 3; i++) apply_vec(hand[i], $sformatf("reject%0d", i));
        cells[0] = 2'b00;
        board = pack_board();
        for (int i = 3; i < 8; i++) apply_vec(hand[i], $sformatf("place%0d", i - 3));

        // Reset while the write strobe is high, then while checking.
        clear_cells();
        do_reset();
        cycle_model(BP, "rst_wr_a");
        cycle_model(B0, "rst_wr_b");
        cycle_model(B0, "rst_wr_c");
        do_reset();
        for (int i = 0; i < 4; i++) cycle_model(B0, "after_rst_wr");
        cycle_model(BP, "rst_chk_a");
        do_reset();
        for (int i = 0; i < 4; i++) cycle_model(B0, "after_rst_chk");

        // Random play until the board is full, then hammer the finished game.
        clear_cells();
        do_reset();
        for (int i = 0; i < 4000 && m_cnt < 16; i++) cycle_model(rand_btn(), "rand_fill");
        n_vec++;
        if (m_cnt != 16 || game_over !== 1'b1 || move_count !== 5'd16) begin
            n_bad++;
            $display("FAIL fill_done: got go=%b cnt=%0d model_cnt=%0d; want go=1 cnt=16",
                     game_over, move_count, m_cnt);
        end
        for (int i = 0; i < 24; i++) cycle_model(BP | rand_btn(), "after_done");

        // Random play with occasional asynchronous resets mid-game.
        clear_cells();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle_model(rand_btn(), "rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
